// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the 4B memory request/response stream and its responder.
package mem_responder_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  localparam logic [1:0] MEM_RESP_TEST = 2'd0;

  // A len of zero encodes a full 4-byte access.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/mem_responder_delay_pipe.sv
// Fixed-latency valid+message shift register; only the valids are reset.
module mem_responder_delay_pipe
  import mem_responder_pkg::*;
#(
  parameter int unsigned p_latency = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  input  mem_resp_4B_t in_msg,
  output logic         out_val,
  output mem_resp_4B_t out_msg
);

  logic [p_latency-1:0] vals;
  mem_resp_4B_t         msgs [p_latency];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vals <= '0;
    end else begin
      vals[0] <= in_val;
      for (int i = 1; i < p_latency; i++) vals[i] <= vals[i-1];
    end
  end

  always_ff @(posedge clk) begin
    msgs[0] <= in_msg;
    for (int i = 1; i < p_latency; i++) msgs[i] <= msgs[i-1];
  end

  assign out_val = vals[p_latency-1];
  assign out_msg = msgs[p_latency-1];

endmodule

// File: rtl/mem_responder.sv
// Behavioural byte-addressable memory behind a val/rdy request/response stream pair.
// Accesses happen at accept time; responses flow through a fixed-latency pipe into an in-order queue.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned p_mem_nbytes  = 4096,
  parameter int unsigned p_latency     = 2,
  parameter int unsigned p_num_entries = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  reqstream_msg,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  output mem_resp_4B_t respstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy
);

  localparam int unsigned AW = $clog2(p_mem_nbytes);
  localparam int unsigned CW = $clog2(p_num_entries + 1);
  localparam int unsigned PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

  logic [7:0]    mem_array [p_mem_nbytes];
  logic [AW-1:0] byte_idx  [4];
  logic [2:0]    nb;
  logic [31:0]   rdata;
  logic          req_go;
  logic          resp_go;
  logic          is_store;
  mem_resp_4B_t  resp_in;
  logic          pipe_val;
  mem_resp_4B_t  pipe_msg;
  logic [CW-1:0] credits;
  logic [CW-1:0] q_count;
  logic [PW-1:0] q_head;
  logic [PW-1:0] q_tail;
  mem_resp_4B_t  q_buf [p_num_entries];
  logic          unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(p_num_entries - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_addr_bits = ^reqstream_msg.addr[31:AW];

  assign req_go   = reqstream_val && reqstream_rdy;
  assign resp_go  = respstream_val && respstream_rdy;
  assign nb       = byte_count(reqstream_msg.len);
  assign is_store = (reqstream_msg.type_ == MEM_TYPE_WRITE) || (reqstream_msg.type_ == MEM_TYPE_INIT);

  // Byte lanes wrap within the addressed word.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      byte_idx[i] = {reqstream_msg.addr[AW-1:2], 2'(reqstream_msg.addr[1:0] + 2'(i))};
      if (3'(i) < nb) rdata[8*i +: 8] = mem_array[byte_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (req_go && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nb) mem_array[byte_idx[i]] <= reqstream_msg.data[8*i +: 8];
      end
    end
  end

  always_comb begin
    resp_in        = '0;
    resp_in.type_  = reqstream_msg.type_;
    resp_in.opaque = reqstream_msg.opaque;
    resp_in.test   = MEM_RESP_TEST;
    resp_in.len    = reqstream_msg.len;
    resp_in.data   = (reqstream_msg.type_ == MEM_TYPE_READ) ? rdata : '0;
  end

  mem_responder_delay_pipe #(.p_latency(p_latency)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_val  (req_go),
    .in_msg  (resp_in),
    .out_val (pipe_val),
    .out_msg (pipe_msg)
  );

  // Credits cover everything in the pipe plus the queue, so enqueue never finds it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= '0;
    end else if (req_go && !resp_go) begin
      credits <= credits + CW'(1);
    end else if (!req_go && resp_go) begin
      credits <= credits - CW'(1);
    end
  end

  assign reqstream_rdy = !reset && (credits < CW'(p_num_entries));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_count <= '0;
      q_head  <= '0;
      q_tail  <= '0;
    end else begin
      if (pipe_val) q_tail <= next_ptr(q_tail);
      if (resp_go)  q_head <= next_ptr(q_head);
      if (pipe_val && !resp_go)      q_count <= q_count + CW'(1);
      else if (!pipe_val && resp_go) q_count <= q_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_val) q_buf[q_tail] <= pipe_msg;
  end

  assign respstream_val = (q_count != '0);
  assign respstream_msg = respstream_val ? q_buf[q_head] : '0;

endmodule
